// File: rtl/ysyx_23060236_mdu_if.sv
// Op/result handshake bundle between the execute stage and the iterative M-extension unit.
interface ysyx_23060236_mdu_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [RD_W-1:0] rd;
    logic            out_valid;
    logic            out_ready;
    logic [RD_W-1:0] out_rd;
    logic [XLEN-1:0] out_val;

    modport master (output in_valid, funct3, src1, src2, rd, out_ready,
                    input  in_ready, out_valid, out_rd, out_val);
    modport slave  (input  in_valid, funct3, src1, src2, rd, out_ready,
                    output in_ready, out_valid, out_rd, out_val);
endinterface

// File: rtl/ysyx_23060236_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, sign fix-up.
// Define YSYX_23060236_MDU_FASTMUL_EN for a single-cycle combinational multiply.
module ysyx_23060236_mdu #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_STEP = 1,
    parameter int unsigned RD_W     = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    output logic               busy,
    ysyx_23060236_mdu_if.slave bus
);
    localparam int unsigned W2    = 2 * XLEN;
    localparam int unsigned CNT_W = $clog2(XLEN + 1);
`ifndef YSYX_23060236_MDU_FASTMUL_EN
    localparam int unsigned MUL_N = XLEN / MUL_STEP;
`endif

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            neg_q, neg_d, rneg_q, rneg_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;
    logic [XLEN-1:0] out_val_q, out_val_d;
    logic [RD_W-1:0] out_rd_q, out_rd_d;

    // Operand signedness, magnitudes and divide special cases at accept
    logic            is_div, sgn1, sgn2, neg1, neg2, div_zero, div_ovf;
    logic [XLEN-1:0] mag1, mag2;
    always_comb begin
        is_div   = bus.funct3[2];
        sgn1     = is_div ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01 || bus.funct3[1:0] == 2'b10);
        sgn2     = is_div ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01);
        neg1     = sgn1 & bus.src1[XLEN-1];
        neg2     = sgn2 & bus.src2[XLEN-1];
        mag1     = neg1 ? -bus.src1 : bus.src1;
        mag2     = neg2 ? -bus.src2 : bus.src2;
        div_zero = is_div && (bus.src2 == '0);
        div_ovf  = is_div && !bus.funct3[0] && (bus.src1 == {1'b1, {(XLEN-1){1'b0}}})
                   && (bus.src2 == {XLEN{1'b1}});
    end

`ifndef YSYX_23060236_MDU_FASTMUL_EN
    // MUL_STEP shift-add iterations per cycle; multiplier sits in the low half of acc
    logic [XLEN:0]   mhi;
    logic [W2-1:0]   mul_nxt;
    always_comb begin
        mhi     = '0;
        mul_nxt = acc_q;
        for (int k = 0; k < MUL_STEP; k++) begin
            mhi     = {1'b0, mul_nxt[W2-1:XLEN]} + (mul_nxt[0] ? {1'b0, opnd_q} : (XLEN+1)'(0));
            mul_nxt = {mhi, mul_nxt[XLEN-1:1]};
        end
    end
`endif

    // One restoring divide step: acc = {remainder, dividend/quotient}
    logic [W2:0]     dsh;
    logic [XLEN:0]   dhi;
    logic [W2-1:0]   div_nxt;
    always_comb begin
        dsh = {acc_q, 1'b0};
        dhi = dsh[W2:XLEN];
        if (dhi >= {1'b0, opnd_q}) begin
            dhi    = dhi - {1'b0, opnd_q};
            dsh[0] = 1'b1;
        end
        div_nxt = {dhi[XLEN-1:0], dsh[XLEN-1:0]};
    end

    // Sign fix-up and result selection
    logic [W2-1:0]   prod;
    logic [XLEN-1:0] quo, rem, res;
    always_comb begin
        prod = neg_q  ? -acc_q : acc_q;
        quo  = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = rneg_q ? -acc_q[W2-1:XLEN] : acc_q[W2-1:XLEN];
        res  = '0;
        case (op_q)
            3'b000:                 res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res = prod[W2-1:XLEN];
            3'b100, 3'b101:         res = quo;
            default:                res = rem;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        out_val_d = out_val_q;
        out_rd_d  = out_rd_q;
        case (state_q)
            S_IDLE: if (bus.in_valid && !flush) begin
                op_d  = bus.funct3;
                rd_d  = bus.rd;
                neg_d = neg1 ^ neg2;
                if (is_div) begin
                    opnd_d  = mag2;
                    rneg_d  = neg1;
                    acc_d   = {XLEN'(0), mag1};
                    cnt_d   = CNT_W'(XLEN - 1);
                    state_d = S_BUSY;
                    // Special results are preloaded as {remainder, quotient}
                    if (div_zero) begin
                        acc_d   = {bus.src1, {XLEN{1'b1}}};
                        neg_d   = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = S_FIX;
                    end else if (div_ovf) begin
                        acc_d   = {XLEN'(0), bus.src1};
                        neg_d   = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = S_FIX;
                    end
                end else begin
                    rneg_d = 1'b0;
`ifdef YSYX_23060236_MDU_FASTMUL_EN
                    acc_d   = W2'(mag1) * W2'(mag2);
                    state_d = S_FIX;
`else
                    opnd_d  = mag1;
                    acc_d   = {XLEN'(0), mag2};
                    cnt_d   = CNT_W'(MUL_N - 1);
                    state_d = S_BUSY;
`endif
                end
            end
            S_BUSY: begin
`ifdef YSYX_23060236_MDU_FASTMUL_EN
                acc_d = div_nxt;
`else
                acc_d = op_q[2] ? div_nxt : mul_nxt;
`endif
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_FIX: begin
                out_val_d = res;
                out_rd_d  = rd_q;
                state_d   = S_DONE;
            end
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
        out_valid_d = (state_d == S_DONE);
        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            opnd_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_val_q   <= '0;
            out_rd_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            opnd_q      <= opnd_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            rneg_q      <= rneg_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_val_q   <= out_val_d;
            out_rd_q    <= out_rd_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_val   = out_val_q;
    assign bus.out_rd    = out_rd_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_ysyx_23060236_mdu.sv
// Directed bench for the iterative multiply/divide unit (default iterative build, MUL_STEP=1).
module tb_ysyx_23060236_mdu;
    logic clock = 1'b0;
    logic reset;
    logic flush;
    logic busy;
    int   errors = 0;
    int   checks = 0;

    ysyx_23060236_mdu_if mif ();

    ysyx_23060236_mdu dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .busy  (busy),
        .bus   (mif)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one op, wait for out_valid, check value/rd/latency; hands off if out_ready is high
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] s1,
                          input logic [31:0] s2, input logic [3:0] rdi,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        @(negedge clock);
        mif.in_valid = 1'b1;
        mif.funct3   = f3;
        mif.src1     = s1;
        mif.src2     = s2;
        mif.rd       = rdi;
        @(posedge clock);
        #1;
        mif.in_valid = 1'b0;
        mif.src1     = 32'hDEAD_BEEF;
        mif.src2     = 32'h0BAD_F00D;
        lat = 1;
        while (!mif.out_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check({tag, "_val"}, 64'(mif.out_val), 64'(exp));
        check({tag, "_rd"},  64'(mif.out_rd), 64'(rdi));
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        if (mif.out_ready) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        logic seen;
        reset         = 1'b1;
        flush         = 1'b0;
        mif.in_valid  = 1'b0;
        mif.funct3    = '0;
        mif.src1      = '0;
        mif.src2      = '0;
        mif.rd        = '0;
        mif.out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready",  64'(mif.in_ready), 64'd1);
        check("rst_out_valid", 64'(mif.out_valid), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_out_val",   64'(mif.out_val), 64'd0);
        check("rst_out_rd",    64'(mif.out_rd), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Multiply
        run_op("mul_7_m3",   3'b000, 32'd7,         32'hFFFF_FFFD, 4'd5,  32'hFFFF_FFEB, 34);
        run_op("mul_big",    3'b000, 32'h1234_5678, 32'd9,         4'd6,  32'hA3D7_0A38, 34);
        run_op("mulhu_ff",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7,  32'hFFFF_FFFE, 34);
        run_op("mulh_ff",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd8,  32'h0000_0000, 34);
        run_op("mulhsu_ff",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd9,  32'hFFFF_FFFF, 34);
        run_op("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 4'd10, 32'h4000_0000, 34);

        // Divide
        run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2,         4'd1,  32'hFFFF_FFFD, 34);
        run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2,         4'd2,  32'hFFFF_FFFF, 34);
        run_op("divu_100_7", 3'b101, 32'd100,       32'd7,         4'd3,  32'd14,        34);
        run_op("remu_100_7", 3'b111, 32'd100,       32'd7,         4'd4,  32'd2,         34);
        run_op("div_7_m2",   3'b100, 32'd7,         32'hFFFF_FFFE, 4'd11, 32'hFFFF_FFFD, 34);
        run_op("rem_7_m2",   3'b110, 32'd7,         32'hFFFF_FFFE, 4'd12, 32'd1,         34);
        run_op("rem_m7_m2",  3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 4'd13, 32'hFFFF_FFFF, 34);
        run_op("divu_min_ff",3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 4'd14, 32'd0,         34);

        // Special cases bypass the iteration
        run_op("div_5_0",    3'b100, 32'd5,         32'd0,         4'd1,  32'hFFFF_FFFF, 2);
        run_op("remu_5_0",   3'b111, 32'd5,         32'd0,         4'd2,  32'd5,         2);
        run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 4'd3,  32'h8000_0000, 2);
        run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 4'd4,  32'd0,         2);

        // Consumer stall holds the result
        mif.out_ready = 1'b0;
        run_op("stall", 3'b101, 32'd100, 32'd7, 4'd9, 32'd14, 34);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check("stall_valid",    64'(mif.out_valid), 64'd1);
            check("stall_val",      64'(mif.out_val), 64'd14);
            check("stall_rd",       64'(mif.out_rd), 64'd9);
            check("stall_in_ready", 64'(mif.in_ready), 64'd0);
        end
        @(negedge clock);
        mif.out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("release_in_ready",  64'(mif.in_ready), 64'd1);
        check("release_out_valid", 64'(mif.out_valid), 64'd0);
        check("release_busy",      64'(busy), 64'd0);

        // Flush during BUSY
        @(negedge clock);
        mif.in_valid = 1'b1;
        mif.funct3   = 3'b100;
        mif.src1     = 32'd1000;
        mif.src2     = 32'd3;
        mif.rd       = 4'd7;
        @(posedge clock);
        #1;
        mif.in_valid = 1'b0;
        check("busy_busy",     64'(busy), 64'd1);
        check("busy_in_ready", 64'(mif.in_ready), 64'd0);
        repeat (9) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        check("flush_busy",     64'(busy), 64'd0);
        check("flush_in_ready", 64'(mif.in_ready), 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (mif.out_valid) seen = 1'b1;
        end
        check("flush_no_valid", 64'(seen), 64'd0);
        run_op("after_flush", 3'b101, 32'd9, 32'd3, 4'd5, 32'd3, 34);

        // Flush wins over in_valid in IDLE
        @(negedge clock);
        mif.in_valid = 1'b1;
        mif.funct3   = 3'b101;
        mif.src1     = 32'd9;
        mif.src2     = 32'd3;
        flush        = 1'b1;
        @(posedge clock);
        #1;
        mif.in_valid = 1'b0;
        flush        = 1'b0;
        check("flush_idle_busy",     64'(busy), 64'd0);
        check("flush_idle_in_ready", 64'(mif.in_ready), 64'd1);

        // Flush together with out_ready in DONE
        mif.out_ready = 1'b0;
        run_op("done_flush", 3'b100, 32'd5, 32'd0, 4'd6, 32'hFFFF_FFFF, 2);
        @(negedge clock);
        flush         = 1'b1;
        mif.out_ready = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        check("done_flush_in_ready",  64'(mif.in_ready), 64'd1);
        check("done_flush_out_valid", 64'(mif.out_valid), 64'd0);

        // Reset mid-BUSY
        @(negedge clock);
        mif.in_valid = 1'b1;
        mif.funct3   = 3'b000;
        mif.src1     = 32'd123;
        mif.src2     = 32'd456;
        mif.rd       = 4'd2;
        @(posedge clock);
        #1;
        mif.in_valid = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_mid_busy",      64'(busy), 64'd0);
        check("rst_mid_in_ready",  64'(mif.in_ready), 64'd1);
        check("rst_mid_out_valid", 64'(mif.out_valid), 64'd0);
        check("rst_mid_out_val",   64'(mif.out_val), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        run_op("after_reset", 3'b101, 32'd9, 32'd3, 4'd8, 32'd3, 34);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
